// File: rtl/matrix_mac_pkg.sv
// Shared definitions for the 4x4 matrix MAC unit and its result reader.
//   MATRIX_DIM / MATRIX_ELEMS : matrix geometry
//   idx_t, coord_t            : linear element index and row/column coordinate
//   state_t                   : reader FSM states
//   map_index()               : linear stream index -> (row, col) for either stream order
package matrix_mac_pkg;

    localparam int unsigned MATRIX_DIM   = 4;
    localparam int unsigned MATRIX_ELEMS = MATRIX_DIM * MATRIX_DIM;

    typedef logic [3:0] idx_t;
    typedef logic [1:0] coord_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef struct packed {
        coord_t row;
        coord_t col;
    } rc_t;

    // Row-major walks columns fastest; column-major walks rows fastest.
    function automatic rc_t map_index(input idx_t idx, input bit row_major);
        rc_t rc;
        if (row_major) begin
            rc.row = idx[3:2];
            rc.col = idx[1:0];
        end else begin
            rc.col = idx[3:2];
            rc.row = idx[1:0];
        end
        return rc;
    endfunction

endpackage

// File: rtl/matrix_result_reader_if.sv
// Valid/ready stream carrying one matrix element per beat, tagged with its
// row, column and a last flag.
//   out_data  : element value
//   out_row   : row index of out_data
//   out_col   : column index of out_data
//   out_last  : final (16th) beat of a drain
//   out_valid : beat valid (driven by master)
//   out_ready : beat accepted (driven by slave)
interface matrix_result_reader_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    import matrix_mac_pkg::*;

    logic [DATA_WIDTH-1:0] out_data;
    coord_t                out_row;
    coord_t                out_col;
    logic                  out_last;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output out_data,
        output out_row,
        output out_col,
        output out_last,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_row,
        input  out_col,
        input  out_last,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/matrix_result_reader.sv
// Drains the MAC result array: on start, snapshots all 16 elements and streams
// them out one per beat, then optionally pulses the MAC clear.
//   i_clock       : clock, rising edge
//   i_reset       : synchronous active-high reset
//   i_start       : drain request, honoured only in IDLE
//   i_clear_after : sampled with start; request a mac_clear pulse at the end
//   i_result_flat : MAC results, element (r,c) at [(r*4+c)*DATA_WIDTH +: DATA_WIDTH]
//   out_if        : element stream (master side)
//   o_busy        : high in STREAM and DONE
//   o_done        : one-cycle pulse after the last beat is accepted
//   o_mac_clear   : one-cycle pulse coincident with o_done when requested
module matrix_result_reader
    import matrix_mac_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter bit          ROW_MAJOR  = 1'b1
) (
    input  logic                                          i_clock,
    input  logic                                          i_reset,
    input  logic                                          i_start,
    input  logic                                          i_clear_after,
    input  logic [MATRIX_DIM*MATRIX_DIM*DATA_WIDTH-1:0]   i_result_flat,
    matrix_result_reader_if.master                        out_if,
    output logic                                          o_busy,
    output logic                                          o_done,
    output logic                                          o_mac_clear
);

    localparam idx_t LAST_IDX = idx_t'(MATRIX_ELEMS - 1);

    state_t                r_state;
    idx_t                  r_index;
    logic                  r_clear_after;
    logic [DATA_WIDTH-1:0] r_snap [MATRIX_ELEMS];

    state_t w_state_next;
    logic   w_capture;
    logic   w_advance;
    logic   w_valid;
    logic   w_beat;
    rc_t    w_rc;
    idx_t   w_elem;

    assign w_rc   = map_index(r_index, ROW_MAJOR);
    assign w_elem = {w_rc.row, w_rc.col};
    assign w_beat = w_valid && out_if.out_ready;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state       <= IDLE;
            r_index       <= '0;
            r_clear_after <= 1'b0;
            for (int i = 0; i < MATRIX_ELEMS; i++) begin
                r_snap[i] <= '0;
            end
        end else begin
            r_state <= w_state_next;
            if (w_capture) begin
                r_index       <= '0;
                r_clear_after <= i_clear_after;
                // Snapshot decouples the stream from later MAC activity.
                for (int i = 0; i < MATRIX_ELEMS; i++) begin
                    r_snap[i] <= i_result_flat[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end else if (w_advance) begin
                r_index <= r_index + idx_t'(1);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_advance    = 1'b0;
        w_valid      = 1'b0;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        o_mac_clear  = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_capture    = 1'b1;
                    w_state_next = STREAM;
                end
            end
            STREAM: begin
                w_valid = 1'b1;
                o_busy  = 1'b1;
                if (w_beat) begin
                    if (r_index == LAST_IDX) begin
                        w_state_next = DONE;
                    end else begin
                        w_advance = 1'b1;
                    end
                end
            end
            DONE: begin
                o_busy       = 1'b1;
                o_done       = 1'b1;
                o_mac_clear  = r_clear_after;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Payload is forced to zero outside STREAM so idle outputs match reset values.
    assign out_if.out_valid = w_valid;
    assign out_if.out_data  = w_valid ? r_snap[w_elem] : '0;
    assign out_if.out_row   = w_valid ? w_rc.row : '0;
    assign out_if.out_col   = w_valid ? w_rc.col : '0;
    assign out_if.out_last  = w_valid && (r_index == LAST_IDX);

endmodule
